// File: rtl/adc_evt_pkg.sv
// adc_evt_pkg: shared constants and types for the ADC event ring buffer.
package adc_evt_pkg;

    localparam int DEF_CH_NUM    = 32;
    localparam int DEF_SMP_W     = 24;
    localparam int DEF_N_SAMPLES = 64;
    localparam int DEF_NUM_SLOTS = 4;
    localparam int DEF_LAT_W     = 6;
    localparam int CNT_W         = 16;
    localparam int EVT_W         = 16;

    typedef logic [EVT_W-1:0] evt_num_t;
    typedef logic [$clog2(DEF_NUM_SLOTS)-1:0] slot_idx_t;

    typedef enum logic {
        WR_IDLE,
        WR_CAPTURE
    } wr_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c
    );
        return (&c) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/adc_evt_slot_ram.sv
// adc_evt_slot_ram: simple dual-port RAM, single clock, registered read.
// A same-address write and read returns the data being written.
module adc_evt_slot_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic             adc_clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge adc_clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/adc_evt_ring_buf.sv
// adc_evt_ring_buf: multi-slot ADC event capture with pre-trigger history.
// Define ADC_EVT_RING_STATS_EN to implement drop_cnt and overlap_cnt.
module adc_evt_ring_buf
    import adc_evt_pkg::*;
#(
    parameter int CH_NUM    = DEF_CH_NUM,
    parameter int SMP_W     = DEF_SMP_W,
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int LAT_W     = DEF_LAT_W,
    parameter int DATA_W    = CH_NUM * SMP_W
)(
    input  logic              adc_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data_in,
    input  logic [LAT_W-1:0]  trigger_latency,
    input  logic              trig_l0,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output evt_num_t          out_evt_num,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  overlap_cnt
);

    localparam int HIST_D = 2 ** LAT_W;
    localparam int SA_W   = $clog2(N_SAMPLES);
    localparam int SL_W   = $clog2(NUM_SLOTS);
    localparam int RA_W   = SL_W + SA_W;
    localparam logic [SA_W-1:0] LAST_A = SA_W'(N_SAMPLES - 1);

    wr_state_e            state;
    logic [LAT_W-1:0]     lat_q;
    logic [LAT_W-1:0]     hist_wptr;
    logic [LAT_W-1:0]     hist_raddr;
    logic [SA_W-1:0]      wr_addr;
    logic [SA_W-1:0]      iss_addr;
    logic [SL_W-1:0]      wr_slot;
    logic [SL_W-1:0]      iss_slot;
    logic [SL_W-1:0]      rd_slot;
    logic [NUM_SLOTS-1:0] full;
    evt_num_t             evt_num;
    evt_num_t             slot_evt [NUM_SLOTS];
    evt_num_t             s1_evt;
    logic [DATA_W-1:0]    hist_rdata;
    logic [DATA_W-1:0]    slot_rdata;
    logic                 capturing;
    logic                 slot_free;
    logic                 accept;
    logic                 commit;
    logic                 avail;
    logic                 issue;
    logic                 free;
    logic                 s1_v;
    logic                 s1_last;
    logic                 s2_take;

    assign capturing = (state == WR_CAPTURE);
    assign slot_free = !full[wr_slot];
    assign accept    = !capturing && trig_l0 && slot_free;
    assign commit    = capturing && (wr_addr == LAST_A);
    assign busy      = capturing || (&full);

    // Read one cycle ahead so the RAM latency lines up with the slot write.
    assign hist_raddr = hist_wptr - (capturing ? lat_q : trigger_latency);

    always_ff @(posedge adc_clk)
        hist_wptr <= hist_wptr + LAT_W'(1);

    adc_evt_slot_ram #(
        .WIDTH (DATA_W),
        .DEPTH (HIST_D),
        .AW    (LAT_W)
    ) u_hist (
        .adc_clk (adc_clk),
        .we      (1'b1),
        .waddr   (hist_wptr),
        .wdata   (adc_data_in),
        .re      (1'b1),
        .raddr   (hist_raddr),
        .rdata   (hist_rdata)
    );

    adc_evt_slot_ram #(
        .WIDTH (DATA_W),
        .DEPTH (NUM_SLOTS * N_SAMPLES),
        .AW    (RA_W)
    ) u_slots (
        .adc_clk (adc_clk),
        .we      (capturing),
        .waddr   ({wr_slot, wr_addr}),
        .wdata   (hist_rdata),
        .re      (issue),
        .raddr   ({iss_slot, iss_addr}),
        .rdata   (slot_rdata)
    );

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state   <= WR_IDLE;
            lat_q   <= '0;
            wr_addr <= '0;
            wr_slot <= '0;
            evt_num <= '0;
        end else begin
            unique case (state)
                WR_IDLE: begin
                    if (accept) begin
                        state   <= WR_CAPTURE;
                        lat_q   <= trigger_latency;
                        wr_addr <= '0;
                        evt_num <= evt_num + EVT_W'(1);
                    end
                end
                WR_CAPTURE: begin
                    wr_addr <= wr_addr + SA_W'(1);
                    if (commit) begin
                        state   <= WR_IDLE;
                        wr_slot <= wr_slot + SL_W'(1);
                    end
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            full <= '0;
            for (int i = 0; i < NUM_SLOTS; i++)
                slot_evt[i] <= '0;
        end else begin
            if (accept)
                slot_evt[wr_slot] <= evt_num;
            if (commit)
                full[wr_slot] <= 1'b1;
            if (free)
                full[rd_slot] <= 1'b0;
        end
    end

    // Start reading a slot in the same cycle it commits.
    assign avail   = full[iss_slot] || (commit && iss_slot == wr_slot);
    assign s2_take = s1_v && (!out_valid || out_ready);
    assign issue   = avail && (!s1_v || s2_take);
    assign free    = out_valid && out_ready && out_last;

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            iss_slot    <= '0;
            iss_addr    <= '0;
            rd_slot     <= '0;
            s1_v        <= 1'b0;
            s1_last     <= 1'b0;
            s1_evt      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_evt_num <= '0;
        end else begin
            if (issue) begin
                iss_addr <= iss_addr + SA_W'(1);
                if (iss_addr == LAST_A)
                    iss_slot <= iss_slot + SL_W'(1);
                s1_v    <= 1'b1;
                s1_last <= (iss_addr == LAST_A);
                s1_evt  <= slot_evt[iss_slot];
            end else if (s2_take) begin
                s1_v <= 1'b0;
            end
            if (s2_take) begin
                out_valid   <= 1'b1;
                out_data    <= slot_rdata;
                out_last    <= s1_last;
                out_evt_num <= s1_evt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (free)
                rd_slot <= rd_slot + SL_W'(1);
        end
    end

`ifdef ADC_EVT_RING_STATS_EN
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] ovl_q;

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            drop_q <= '0;
            ovl_q  <= '0;
        end else begin
            if (!capturing && trig_l0 && !slot_free)
                drop_q <= sat_inc(drop_q);
            if (capturing && trig_l0)
                ovl_q <= sat_inc(ovl_q);
        end
    end

    assign drop_cnt    = drop_q;
    assign overlap_cnt = ovl_q;
`else
    assign drop_cnt    = '0;
    assign overlap_cnt = '0;
`endif

endmodule

// File: tb/tb_adc_evt_ring_buf.sv
// tb_adc_evt_ring_buf: directed bench with a frame scoreboard.
// Input is a ramp, so each expected frame value follows from trigger time and L.
module tb_adc_evt_ring_buf;
    import adc_evt_pkg::*;

    localparam int CH_NUM = 32;
    localparam int SMP_W  = 24;
    localparam int DATA_W = CH_NUM * SMP_W;
    localparam int N      = 64;
    localparam int LAT_W  = 6;

`ifdef ADC_EVT_RING_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    typedef struct {
        int v;
        bit last;
        int evt;
    } exp_t;

    logic              adc_clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] adc_data_in;
    logic [LAT_W-1:0]  trigger_latency = '0;
    logic              trig_l0 = 1'b0;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    evt_num_t          out_evt_num;
    logic [15:0]       drop_cnt;
    logic [15:0]       overlap_cnt;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_last = 0;
    int   tb_evt = 0;
    int   rdy_mode = 1;
    exp_t exp_q[$];
    exp_t e;

    bit                stall_prev = 0;
    bit                in_evt = 0;
    logic [DATA_W-1:0] held_d;
    logic              held_l;
    logic [15:0]       held_e;

    adc_evt_ring_buf dut (
        .adc_clk         (adc_clk),
        .rst             (rst),
        .adc_data_in     (adc_data_in),
        .trigger_latency (trigger_latency),
        .trig_l0         (trig_l0),
        .busy            (busy),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .out_evt_num     (out_evt_num),
        .drop_cnt        (drop_cnt),
        .overlap_cnt     (overlap_cnt)
    );

    always #5 adc_clk = ~adc_clk;

    always @(posedge adc_clk)
        cyc <= cyc + 1;

    assign adc_data_in = {CH_NUM{cyc[23:0]}};

    function automatic logic [DATA_W-1:0] frame(input int v);
        return {CH_NUM{v[23:0]}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge adc_clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge adc_clk) begin
        if (rst) begin
            stall_prev = 0;
            in_evt     = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data == held_d), 1);
                chk("hold_last", 32'(out_last), 32'(held_l));
                chk("hold_evt", 32'(out_evt_num), 32'(held_e));
            end
            if (in_evt && rdy_mode == 1)
                chk("no_gap", 32'(out_valid), 1);
            if (out_valid && out_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("data_lo", out_data[31:0], frame(e.v) >> 0);
                    chk("data_hi", out_data[DATA_W-1 -: 32],
                        32'(frame(e.v) >> (DATA_W - 32)));
                    chk("last", 32'(out_last), 32'(e.last));
                    chk("evt", 32'(out_evt_num), e.evt);
                end
                if (out_last)
                    n_last++;
                in_evt = !out_last;
            end
            stall_prev = out_valid && !out_ready;
            held_d     = out_data;
            held_l     = out_last;
            held_e     = out_evt_num;
        end
    end

    task automatic do_reset();
        @(negedge adc_clk);
        rst = 1'b1;
        exp_q.delete();
        tb_evt = 0;
        repeat (3) @(negedge adc_clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_data", 32'(out_data == '0), 1);
        chk("rst_evt", 32'(out_evt_num), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_overlap", 32'(overlap_cnt), 0);
        rst    = 1'b0;
        n_last = 0;
    endtask

    task automatic trig(input int lat, input bit acc);
        int t;
        @(negedge adc_clk);
        trigger_latency = LAT_W'(lat);
        trig_l0 = 1'b1;
        t = cyc;
        if (acc) begin
            for (int k = 0; k < N; k++)
                exp_q.push_back('{v: t - lat + k, last: (k == N - 1), evt: tb_evt});
            tb_evt++;
        end
        @(negedge adc_clk);
        trig_l0 = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < budget) begin
            @(negedge adc_clk);
            k++;
        end
        chk("drain_in_time", 32'(k < budget), 1);
    endtask

    initial begin
        int  j;
        bit  seen;

        do_reset();

        // single event, L=10, trigger at cycle 100
        rdy_mode = 1;
        while (cyc < 99) @(negedge adc_clk);
        trig(10, 1);
        chk("t1_busy_rise", 32'(busy), 1);
        j = 0;
        while (!out_valid && j < 200) begin
            @(negedge adc_clk);
            j++;
        end
        chk("t1_valid_not_early", 32'(j >= N + 1), 1);
        chk("t1_valid_not_late", 32'(j <= N + 2), 1);
        wait_drain(300);
        chk("t1_last_cnt", n_last, 1);
        chk("t1_busy_fall", 32'(busy), 0);

        // overflow: five triggers, reader stalled
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) begin
            trig(5, i < 4);
            if (i < 4) repeat (69) @(negedge adc_clk);
        end
        chk("t2_busy_full", 32'(busy), 1);
        chk("t2_drop", 32'(drop_cnt), STATS);
        chk("t2_overlap", 32'(overlap_cnt), 0);
        chk("t2_stalled_valid", 32'(out_valid), 1);
        rdy_mode = 1;
        wait_drain(600);
        chk("t2_last_cnt", n_last, 4);
        chk("t2_busy_clear", 32'(busy), 0);
        chk("t2_drop_kept", 32'(drop_cnt), STATS);

        // overlap: second trigger 20 cycles in, L=0
        do_reset();
        rdy_mode = 1;
        trig(0, 1);
        repeat (19) @(negedge adc_clk);
        trig(3, 0);
        chk("t3_overlap", 32'(overlap_cnt), STATS);
        chk("t3_drop", 32'(drop_cnt), 0);
        wait_drain(300);
        chk("t3_last_cnt", n_last, 1);

        // random backpressure, L=63
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) begin
            trig(63, 1);
            repeat (69) @(negedge adc_clk);
        end
        wait_drain(3000);
        rdy_mode = 1;
        chk("t4_last_cnt", n_last, 3);

        // reset in the middle of a capture
        do_reset();
        rdy_mode = 1;
        trig(4, 1);
        repeat (29) @(negedge adc_clk);
        do_reset();
        seen = 0;
        repeat (100) begin
            @(negedge adc_clk);
            if (out_valid) seen = 1;
        end
        chk("t5_no_valid", 32'(seen), 0);
        chk("t5_busy", 32'(busy), 0);
        trig(2, 1);
        wait_drain(300);
        chk("t5_last_cnt", n_last, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
